// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator for a word-organised, big-endian byte-lane data RAM.
// Optional misalignment exception enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        stall_req_o,
  output logic        exc_misalign_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam int unsigned CW = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_resp_valid;
  logic [31:0]   r_rdata;
  logic          r_exc;

  logic          w_access;
  logic          w_misalign;
  logic [3:0]    w_sel;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  assign w_access = (r_state == S_ACCESS);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_sel   = '0;
    w_wdata = '0;
    if (w_access) begin
      case (r_size)
        2'b00: begin
          w_sel   = 4'b1000 >> r_addr[1:0];
          w_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          w_sel   = r_addr[1] ? 4'b0011 : 4'b1100;
          w_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          w_sel   = 4'b1111;
          w_wdata = r_wdata;
        end
      endcase
    end
  end

  // Big-endian lane pick: offset 0 is the most significant byte.
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = mem_data_i[31:24];
      2'b01:   w_byte = mem_data_i[23:16];
      2'b10:   w_byte = mem_data_i[15:8];
      default: w_byte = mem_data_i[7:0];
    endcase
    w_half = r_addr[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_exc        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_size   <= req_size_i;
            r_signed <= req_signed_i;
            r_addr   <= req_addr_i;
            r_wdata  <= req_wdata_i;
            r_cnt    <= '0;
            if (w_misalign) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_exc        <= 1'b1;
              r_rdata      <= '0;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == LAST) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= r_we ? '0 : w_load;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_rdata      <= '0;
          r_exc        <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o    = (r_state == S_IDLE);
  assign stall_req_o    = w_access | ((r_state == S_IDLE) & req_valid_i);
  assign resp_valid_o   = r_resp_valid;
  assign resp_rdata_o   = r_rdata;
  assign exc_misalign_o = r_exc;
  assign mem_ce_o       = w_access & ~rst;
  assign mem_we_o       = w_access & r_we & ~rst;
  assign mem_addr_o     = {r_addr[31:2], 2'b00};
  assign mem_sel_o      = w_sel;
  assign mem_data_o     = w_wdata;

endmodule
